// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: load/store request, load result
// and the completion/stall handshake back to the pipeline.
interface sram_controller_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic        SRAM_Freeze;

    // Pipeline (MEM stage) view
    modport master (
        output MEM_R_EN, MEM_W_EN, address, writeData,
        input  readData, ready, SRAM_Freeze
    );

    // Controller view
    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, writeData,
        output readData, ready, SRAM_Freeze
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit accesses on the
// external SRAM (low half first), freezing the pipeline until the word is done.
module sram_controller #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] DATA_BASE     = 32'd1024
) (
    input  logic               clk,
    input  logic               reset,
    sram_controller_if.slave   mem,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [16:0] idx_reg, idx_next;
    logic        write_reg, write_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rdata_reg, rdata_next;

    logic        request;
    logic        last;
    logic        active;
    logic [16:0] req_idx;
    logic [15:0] dq_out;

    assign request = mem.MEM_R_EN | mem.MEM_W_EN;
    assign last    = (cnt_reg == LAST);
    assign active  = (state_reg == LOW) || (state_reg == HIGH);
    // Word index relative to DATA_BASE; the subtraction wraps at 32 bits and
    // the byte offset within the word is dropped.
    assign req_idx = 17'((mem.address - DATA_BASE) >> 2);

    // State and datapath registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            write_reg <= write_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
        end
    end

    // Next-state logic: latch the request in IDLE, time each half, capture reads
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        write_next = write_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    idx_next   = req_idx;
                    write_next = mem.MEM_W_EN;   // both enables high => store
                    wdata_next = mem.writeData;
                end
            end
            LOW: begin
                if (last) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    if (!write_reg) begin
                        rdata_next[15:0] = SRAM_DQ;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    if (!write_reg) begin
                        rdata_next[31:16] = SRAM_DQ;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                // Pipeline moves on at this edge, so a lingering request is not re-served
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SRAM pin drive: address and data held for the whole half-access
    assign dq_out    = (state_reg == HIGH) ? wdata_reg[31:16] : wdata_reg[15:0];
    assign SRAM_DQ   = (active && write_reg) ? dq_out : 16'bz;
    assign SRAM_ADDR = active ? {idx_reg, (state_reg == HIGH)} : '0;
    assign SRAM_WE_N = !(active && write_reg);
    assign SRAM_OE_N = !(active && !write_reg);
    assign SRAM_CE_N = !reset;
    assign SRAM_UB_N = !reset;
    assign SRAM_LB_N = !reset;

    // Pipeline handshake; the stall is combinational so it lands in the request cycle
    assign mem.readData    = rdata_reg;
    assign mem.ready       = (state_reg == DONE);
    assign mem.SRAM_Freeze = reset && (((state_reg == IDLE) && request) || active);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: one instance at ACCESS_CYCLES=2 and one at 1,
// each with a small SRAM model on its data bus.
module tb_sram_controller;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ready_cnt0 = 0;
    logic probe_en = 1'b0;
    logic pre_en = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    exp_t q0[$];
    exp_t q1[$];

    sram_controller_if m();
    sram_controller_if m1();

    wire  [15:0] dq0, dq1;
    logic [17:0] addr0, addr1;
    logic we0, oe0, ce0, ub0, lb0;
    logic we1, oe1, ce1, ub1, lb1;

    logic [15:0] mem0 [0:1023];
    logic [15:0] mem1 [0:1023];

    sram_controller #(.ACCESS_CYCLES(2), .DATA_BASE(32'd1024)) dut (
        .clk(clk), .reset(reset), .mem(m),
        .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_controller #(.ACCESS_CYCLES(1), .DATA_BASE(32'd1024)) dut1 (
        .clk(clk), .reset(reset), .mem(m1),
        .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // SRAM models drive the bus on output-enable; the probe drives a known
    // pattern so a released bus reads back as that pattern
    assign dq0 = (!oe0) ? mem0[addr0[9:0]] : 16'bz;
    assign dq0 = probe_en ? 16'hA5C3 : 16'bz;
    assign dq1 = (!oe1) ? mem1[addr1[9:0]] : 16'bz;
    assign dq1 = probe_en ? 16'hA5C3 : 16'bz;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!we0) mem0[addr0[9:0]] <= dq0;
        if (pre_en) mem0[pre_addr] <= pre_data;
        if (!we1) mem1[addr1[9:0]] <= dq1;
    end

    always @(negedge clk) begin
        if (m.ready) ready_cnt0 <= ready_cnt0 + 1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One complete transaction on either instance, checked every cycle
    task automatic run_op(input bit sel1, input logic r, input logic w,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, output int nfreeze);
        int a;
        logic [31:0] offs;
        logic [17:0] base_addr;
        logic half;
        exp_t e;
        exp_t got;
        logic [17:0] cur_addr;
        logic [15:0] cur_dq;
        logic [31:0] cur_rd;
        logic cur_we, cur_oe, cur_rdy, cur_frz;
        a = sel1 ? 1 : 2;
        offs = addr - 32'd1024;
        base_addr = {offs[18:2], 1'b0};
        e.rdata = exp_rdata;
        e.cyc = cyc + 2 * a + 1;
        if (sel1) begin
            m1.MEM_R_EN = r; m1.MEM_W_EN = w; m1.address = addr; m1.writeData = wdata;
            q1.push_back(e);
        end else begin
            m.MEM_R_EN = r; m.MEM_W_EN = w; m.address = addr; m.writeData = wdata;
            q0.push_back(e);
        end
        nfreeze = 0;
        for (int c = 0; c <= 2 * a + 1; c++) begin
            probe_en = (c == 0) || (c == 2 * a + 1);
            @(negedge clk);
            cur_addr = sel1 ? addr1 : addr0;
            cur_dq   = sel1 ? dq1 : dq0;
            cur_we   = sel1 ? we1 : we0;
            cur_oe   = sel1 ? oe1 : oe0;
            cur_rdy  = sel1 ? m1.ready : m.ready;
            cur_frz  = sel1 ? m1.SRAM_Freeze : m.SRAM_Freeze;
            cur_rd   = sel1 ? m1.readData : m.readData;
            if (cur_frz) nfreeze++;
            chk("freeze", 32'(cur_frz), 32'(c <= 2 * a));
            chk("ready", 32'(cur_rdy), 32'(c == 2 * a + 1));
            if (c >= 1 && c <= 2 * a) begin
                half = (c > a);
                chk("sram_addr", 32'(cur_addr), 32'(base_addr | 18'(half)));
                chk("we_n", 32'(cur_we), 32'(!w));
                chk("oe_n", 32'(cur_oe), 32'(w));
                if (w) chk("dq_write", 32'(cur_dq), 32'(half ? wdata[31:16] : wdata[15:0]));
            end else begin
                chk("we_n_idle", 32'(cur_we), 32'd1);
                chk("oe_n_idle", 32'(cur_oe), 32'd1);
                chk("dq_released", 32'(cur_dq), 32'h0000A5C3);
            end
            if (cur_rdy) begin
                if ((sel1 ? q1.size() : q0.size()) == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ready cyc=%0d actual=pulse required=none", cyc);
                end else begin
                    got = sel1 ? q1.pop_front() : q0.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(got.cyc));
                    chk("readData", cur_rd, got.rdata);
                end
            end
            @(posedge clk); #1;
        end
        if (sel1) begin m1.MEM_R_EN = 1'b0; m1.MEM_W_EN = 1'b0; end
        else begin m.MEM_R_EN = 1'b0; m.MEM_W_EN = 1'b0; end
        probe_en = 1'b0;
    endtask

    initial begin
        vec_t tbl [9];
        int nf;
        int rc;
        tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'h11112222, 32'h0F0F1E1E};
        tbl[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h11112222};
        tbl[2] = '{1'b0, 1'b1, 32'd1035, 32'hCAFEF00D, 32'h11112222};
        tbl[3] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hCAFEF00D};
        tbl[4] = '{1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, 32'hCAFEF00D};
        tbl[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'h0BADC0DE};
        tbl[6] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h11112222};
        tbl[7] = '{1'b1, 1'b1, 32'd1028, 32'h55AA33CC, 32'h11112222};
        tbl[8] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h55AA33CC};

        // Reset held for 3 cycles with a load request pending
        reset = 1'b0;
        m.MEM_R_EN = 1'b1; m.MEM_W_EN = 1'b0; m.address = 32'd1032; m.writeData = '0;
        m1.MEM_R_EN = 1'b1; m1.MEM_W_EN = 1'b0; m1.address = 32'd1032; m1.writeData = '0;
        probe_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_readData", m.readData, 32'd0);
            chk("rst_ready", 32'(m.ready), 32'd0);
            chk("rst_freeze", 32'(m.SRAM_Freeze), 32'd0);
            chk("rst_we_n", 32'(we0), 32'd1);
            chk("rst_oe_n", 32'(oe0), 32'd1);
            chk("rst_ce_ub_lb", 32'({ce0, ub0, lb0}), 32'd7);
            chk("rst_addr", 32'(addr0), 32'd0);
            chk("rst_dq", 32'(dq0), 32'h0000A5C3);
            chk("rst_freeze1", 32'(m1.SRAM_Freeze), 32'd0);
            chk("rst_dq1", 32'(dq1), 32'h0000A5C3);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m.MEM_R_EN = 1'b0; m1.MEM_R_EN = 1'b0;
        probe_en = 1'b0;
        @(negedge clk);
        chk("run_ce_ub_lb", 32'({ce0, ub0, lb0, ce1}), 32'd0);
        @(posedge clk); #1;

        // Store: two half-writes, ready in cycle 5, freeze for 5 cycles
        run_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0, nf);
        chk("store_freeze_cycles", 32'(nf), 32'd5);
        chk("store_mem_lo", 32'(mem0[4]), 32'h0000BEEF);
        chk("store_mem_hi", 32'(mem0[5]), 32'h0000DEAD);

        // Load from preloaded model
        pre_en = 1'b1; pre_addr = 10'd4; pre_data = 16'h1234;
        @(posedge clk); #1;
        pre_addr = 10'd5; pre_data = 16'hABCD;
        @(posedge clk); #1;
        pre_en = 1'b0;
        run_op(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, 32'hABCD1234, nf);

        // Back-to-back store then load; store must leave readData unchanged
        rc = ready_cnt0;
        run_op(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0F0F1E1E, 32'hABCD1234, nf);
        run_op(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 32'h0F0F1E1E, nf);
        chk("b2b_ready_pulses", 32'(ready_cnt0 - rc), 32'd2);

        // Table of mixed transactions incl. address wrap and ignored byte offset
        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, nf);
            chk("tbl_freeze_cycles", 32'(nf), 32'd5);
        end

        // Reset in cycle 3 of a store: back to IDLE, bus released, no ready
        rc = ready_cnt0;
        m.MEM_W_EN = 1'b1; m.address = 32'd1032; m.writeData = 32'h77778888;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        probe_en = 1'b1;
        @(negedge clk);
        chk("mwr_we_n", 32'(we0), 32'd1);
        chk("mwr_oe_n", 32'(oe0), 32'd1);
        chk("mwr_dq", 32'(dq0), 32'h0000A5C3);
        chk("mwr_ready", 32'(m.ready), 32'd0);
        chk("mwr_freeze", 32'(m.SRAM_Freeze), 32'd0);
        chk("mwr_readData", m.readData, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        m.MEM_W_EN = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mwr_idle_ready", 32'(m.ready), 32'd0);
            chk("mwr_idle_freeze", 32'(m.SRAM_Freeze), 32'd0);
            chk("mwr_idle_dq", 32'(dq0), 32'h0000A5C3);
            @(posedge clk); #1;
        end
        probe_en = 1'b0;
        chk("mwr_no_ready", 32'(ready_cnt0 - rc), 32'd0);

        // A=1: both enables high runs as a store, ready in cycle 3
        run_op(1'b1, 1'b1, 1'b1, 32'd1028, 32'h13572468, 32'h0, nf);
        chk("a1_freeze_cycles", 32'(nf), 32'd3);
        chk("a1_mem_lo", 32'(mem1[2]), 32'h00002468);
        chk("a1_mem_hi", 32'(mem1[3]), 32'h00001357);
        run_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h13572468, nf);
        chk("a1_load_freeze_cycles", 32'(nf), 32'd3);

        chk("pending0", 32'(q0.size()), 32'd0);
        chk("pending1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage responder for the 16-bit external SRAM. It turns each 32-bit load or store from the MEM stage into two 16-bit SRAM accesses. While an access is in flight it raises `SRAM_Freeze`, which holds every pipeline register (IF, ID, EXE, MEM). It releases the pipeline with a one-cycle `ready` once the word is complete.

## Interface

Parameters:
- `ACCESS_CYCLES`, default 2: cycles each 16-bit half-access is held on the SRAM pins; legal range 1..15.
- `DATA_BASE`, default 32'd1024: byte address mapped to SRAM word 0.

Ports:
- `clk` — input, 1: single clock; all state changes on the rising edge.
- `reset` — input, 1: synchronous, active-low.
- `MEM_R_EN` — input, 1: load request from the MEM stage.
- `MEM_W_EN` — input, 1: store request from the MEM stage.
- `address` — input, 32: byte address from the ALU.
- `writeData` — input, 32: store data.
- `readData` — output, 32: registered load result.
- `ready` — output, 1: one-cycle completion pulse.
- `SRAM_Freeze` — output, 1: stall for all pipeline registers.
- `SRAM_DQ` — inout, 16: SRAM data bus.
- `SRAM_ADDR` — output, 18: SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` — output, 1 each: SRAM strobes, all active-low.

## Operation

States are IDLE, LOW, HIGH and DONE. A 4-bit phase counter `cnt` runs inside LOW and HIGH.

Address mapping:
- `offs = address - DATA_BASE`, computed at 32 bits and wrapping modulo 2^32.
- `idx = offs[18:2]`.
- `SRAM_ADDR = {idx, half}`, where `half` is 0 in LOW and 1 in HIGH.
- `offs[1:0]` is ignored.

State transitions and actions:
- **IDLE**
  - Request means `MEM_R_EN | MEM_W_EN`.
  - On a request: latch `idx`, the op type and `writeData` into internal registers; go to LOW with `cnt=0`.
  - If both enables are high, the op is a write.
- **LOW**
  - Drive the latched address with `half=0`.
  - Write: `SRAM_DQ = wdata[15:0]` and `SRAM_WE_N=0`, for the whole phase.
  - Read: `SRAM_DQ` is Z and `SRAM_OE_N=0`. On the last cycle (`cnt==ACCESS_CYCLES-1`), capture `SRAM_DQ` into `readData[15:0]`.
  - On the last cycle, go to HIGH with `cnt=0`; otherwise `cnt++`.
- **HIGH**
  - Same as LOW, but with `half=1`, `wdata[31:16]` and `readData[31:16]`.
  - On the last cycle, go to DONE.
- **DONE**
  - `ready=1` for exactly one cycle; `SRAM_Freeze=0`.
  - Next state is IDLE unconditionally. The pipeline advances on this edge, so a request still visible in DONE is not re-served.

Outputs:
- `SRAM_Freeze = (state==IDLE & (MEM_R_EN|MEM_W_EN)) | state==LOW | state==HIGH`. This is combinational, so the stage registers see the stall in the same cycle the request appears.
- `readData` holds its value until the next read captures into it; writes leave it unchanged.
- Strobes:
  - `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` are 0 whenever `reset=1`.
  - `SRAM_WE_N` and `SRAM_OE_N` are 1 outside the phases above.
  - `SRAM_DQ` is Z in IDLE and DONE.

Boundary conditions:
- Enables dropping mid-transaction are ignored; the latched op completes.
- New requests are not accepted in LOW, HIGH or DONE.
- `reset=0` at any edge forces IDLE, `cnt=0`, `readData=0` and releases `SRAM_DQ`. This applies even mid-write, and the partial write is not retried.

## Timing

Reset values:
- `readData=0`, `ready=0`, `SRAM_Freeze=0`.
- `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_CE_N=1`, `SRAM_UB_N=1`, `SRAM_LB_N=1`.
- `SRAM_ADDR=0`, `SRAM_DQ` Z.

Latency:
- For a request first visible in cycle 0, the FSM is in LOW for cycles 1..A and HIGH for cycles A+1..2A, where A = `ACCESS_CYCLES`.
- DONE (`ready=1`) is cycle 2A+1.
- `SRAM_Freeze` is high for cycles 0..2A, i.e. 2A+1 cycles; with the default A=2 that is 5 cycles.

Bus stability:
- Address, data and `WE_N` are stable for all A cycles of a phase.
- No `WE_N` glitch between LOW and HIGH is required; the address changes together with the data.

Back-to-back requests: with a request present in the cycle after DONE, IDLE accepts it immediately. The minimum spacing is 2A+2 cycles per access.

## Test plan

- **Reset:** hold `reset=0` for 3 cycles with `MEM_R_EN=1`. Required: every output at its reset value and `SRAM_DQ` is Z.
- **Store:** `address=1032`, `writeData=32'hDEADBEEF`, A=2.
  - Cycles 1–2: `SRAM_ADDR=18'd4`, `DQ=16'hBEEF`, `WE_N=0`.
  - Cycles 3–4: `SRAM_ADDR=18'd5`, `DQ=16'hDEAD`, `WE_N=0`.
  - `ready` pulses in cycle 5; `SRAM_Freeze` is high in cycles 0–4.
- **Load:** preload the SRAM model with address 4 = `16'h1234` and address 5 = `16'hABCD`, then load from `address=1032`. Required: `readData=32'hABCD1234` in cycle 5, held through later stores.
- **Back-to-back:** store to 1024 followed immediately by load from 1024. Required: the load returns the stored word, the second request starts the cycle after `ready`, and exactly two `ready` pulses occur.
- **Mid-write reset:** assert `reset=0` in cycle 3 of a store. Required: IDLE on the next edge, `WE_N=1`, `DQ` Z, no `ready`.
- **Both enables high, A=1:** required: the op runs as a write, `ready` pulses in cycle 3, and `SRAM_Freeze` is high for exactly 3 cycles.
